game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Top-level game sequencer for the brick-breaker datapath. Owns the game FSM:
//  start, field load, serve, play, ball loss, level clear and game over.
//  Drives the active-low clear of the brick/score block, gates the ball-motion
//  block, and tracks lives and level. Sits between the user inputs and the
//  ball-motion and brick/score blocks.
// PARAMETERS
//  LIVES_INIT  3   lives at new game (1..3, fits 2-bit lives)
//  SERVE_TICKS 4   game ticks held in SERVE before the ball moves
//  CLEAR_TICKS 6   game ticks held in CLEAR before the next level loads
//  LOSS_ROW    11  ball row index that means the ball was missed
//  LEVEL_MAX   7   level saturates here (3-bit level)
// PORTS
//  clock         in   1   system clock
//  reset         in   1   asynchronous, active-high reset
//  tick          in   1   one-clock strobe at the game step rate (2 Hz)
//  start_btn     in   1   start button, already synchronised, level signal
//  ball_row      in   4   current ball row index
//  bricks        in   72  brick bitmap from the brick/score block
//  field_reset_n out  1   active-low clear to the brick/score block
//  serve_req     out  1   one-clock pulse: ball block places ball on paddle
//  ball_enable   out  1   1 = ball block may advance on tick
//  lives         out  2   remaining lives
//  level         out  3   current level, 0-based
//  game_over     out  1   1 while in OVER
//  state         out  3   FSM state code, for display/debug
// BEHAVIOUR
//  Reset values: state=IDLE, field_reset_n=0, serve_req=0, ball_enable=0,
//   lives=LIVES_INIT, level=0, game_over=0; tick counter=0; start_q=0.
//  All outputs are registered. start_q is the previous start_btn sample.
//   start_rise = start_btn & ~start_q. field_reset_n=1 from the first clock after reset.
//  State codes: IDLE=0 LOAD=1 SERVE=2 PLAY=3 MISS=4 CLEAR=5 OVER=6.
//  IDLE: on start_rise, set new_game=1 and go to LOAD.
//  LOAD: field_reset_n=0 for exactly 2 clocks. If new_game, lives=LIVES_INIT
//   and level=0, then clear new_game. Then go to SERVE.
//  SERVE: serve_req=1 on the first clock in SERVE only. Count tick strobes.
//   On the SERVE_TICKS-th tick, go to PLAY. ball_enable=0 throughout.
//  PLAY: ball_enable=1. Evaluated only on a clock where tick=1:
//   - bricks==0 -> CLEAR. This has priority over a simultaneous loss.
//   - else ball_row==LOSS_ROW -> MISS.
//   Clocks without tick never change state.
//  MISS: lasts 1 clock with ball_enable=0.
//   If lives==1: lives=0 and go to OVER. Else lives-=1 and go to SERVE.
//   lives never wraps below 0.
//  CLEAR: ball_enable=0. Count CLEAR_TICKS ticks, then:
//   level = min(level+1, LEVEL_MAX), new_game=0, go to LOAD.
//   Lives are kept across levels.
//  OVER: game_over=1, ball_enable=0. On start_rise, set new_game=1 and go to LOAD.
//  Tick counter clears on every state entry.
//  start_rise is ignored in LOAD, SERVE, PLAY, MISS and CLEAR.
//  A tick coincident with state entry is not counted (counter starts next clock).
//  Reset asserted mid-game: all registers return to reset values immediately (async).
//   The brick/score block is held cleared via field_reset_n=0 while reset is high.
// TESTING
//  1 Reset, start_btn 0->1: LOAD shows field_reset_n=0 for 2 clocks, serve_req
//    pulses once, then 4 ticks later state=3 and ball_enable=1, lives=3, level=0.
//  2 In PLAY, ball_row=11 on a tick: MISS then SERVE, lives=2. Repeat twice:
//    lives=0, game_over=1, state=6. Further ticks leave the state unchanged.
//  3 In PLAY, bricks=0 and ball_row=11 on the same tick: CLEAR wins. After 6 ticks
//    LOAD runs, level=1, lives unchanged.
//  4 Drive 8 level clears: level saturates at 7 and does not wrap.
//  5 start_btn held high through OVER: no restart. A fresh 0->1 edge gives LOAD
//    with lives=3 and level=0. A start edge during PLAY is ignored.
//  6 Assert reset in PLAY mid-tick: outputs go to reset values without waiting
//    for a clock edge. After release, field_reset_n=1 on the next clock and state=IDLE.

Source files
------------

// File: rtl/game_flow_if.sv
// Signal bundle between the game sequencer and its surroundings: user inputs and
// datapath status come in, field/ball control and game status go out.
interface game_flow_if;
  logic        i_tick;
  logic        i_start_btn;
  logic [3:0]  i_ball_row;
  logic [71:0] i_bricks;
  logic        o_field_reset_n;
  logic        o_serve_req;
  logic        o_ball_enable;
  logic [1:0]  o_lives;
  logic [2:0]  o_level;
  logic        o_game_over;
  logic [2:0]  o_state;

  modport master (
    output i_tick, i_start_btn, i_ball_row, i_bricks,
    input  o_field_reset_n, o_serve_req, o_ball_enable, o_lives, o_level,
           o_game_over, o_state
  );

  modport slave (
    input  i_tick, i_start_btn, i_ball_row, i_bricks,
    output o_field_reset_n, o_serve_req, o_ball_enable, o_lives, o_level,
           o_game_over, o_state
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Brick-breaker game sequencer: start, field load, serve, play, ball loss, level
// clear and game over; owns lives/level and gates the ball and brick blocks.
module game_flow_ctrl #(
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned SERVE_TICKS = 4,
  parameter int unsigned CLEAR_TICKS = 6,
  parameter int unsigned LOSS_ROW    = 11,
  parameter int unsigned LEVEL_MAX   = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  game_flow_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SERVE = 3'd2,
    S_PLAY  = 3'd3,
    S_MISS  = 3'd4,
    S_CLEAR = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  localparam logic [1:0] LIVES_RST  = 2'(LIVES_INIT);
  localparam logic [3:0] SERVE_LAST = 4'(SERVE_TICKS - 1);
  localparam logic [3:0] CLEAR_LAST = 4'(CLEAR_TICKS - 1);
  localparam logic [3:0] LOSS_IDX   = 4'(LOSS_ROW);
  localparam logic [2:0] LEVEL_TOP  = 3'(LEVEL_MAX);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_start_q;
  logic       r_new_game;
  logic       r_load_cnt;
  logic [3:0] r_tick_cnt;
  logic [1:0] r_lives;
  logic [2:0] r_level;
  logic       r_field_reset_n;
  logic       r_serve_req;
  logic       r_ball_enable;
  logic       r_game_over;

  logic       w_start_rise;
  logic       w_new_game;
  logic       w_load_cnt;
  logic [3:0] w_tick_cnt;
  logic [1:0] w_lives;
  logic [2:0] w_level;

  assign w_start_rise = bus.i_start_btn & ~r_start_q;

  // Next-state and next-value logic for the game FSM and its counters
  always_comb begin
    w_next_state = r_state;
    w_lives      = r_lives;
    w_level      = r_level;
    w_new_game   = r_new_game;
    w_load_cnt   = 1'b0;
    w_tick_cnt   = r_tick_cnt;

    case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_rise) begin
          w_next_state = S_LOAD;
          w_new_game   = 1'b1;
        end else begin
          w_next_state = r_state;
        end
      end
      S_LOAD: begin
        // Two clocks here: the first arms r_load_cnt, the second leaves
        if (r_load_cnt) begin
          w_next_state = S_SERVE;
        end else begin
          w_load_cnt = 1'b1;
          if (r_new_game) begin
            w_lives    = LIVES_RST;
            w_level    = 3'd0;
            w_new_game = 1'b0;
          end else begin
            w_new_game = 1'b0;
          end
        end
      end
      S_SERVE: begin
        if (bus.i_tick && (r_tick_cnt == SERVE_LAST)) begin
          w_next_state = S_PLAY;
        end else begin
          w_next_state = S_SERVE;
        end
      end
      S_PLAY: begin
        if (bus.i_tick) begin
          if (bus.i_bricks == 72'd0) begin
            w_next_state = S_CLEAR;
          end else if (bus.i_ball_row == LOSS_IDX) begin
            w_next_state = S_MISS;
          end else begin
            w_next_state = S_PLAY;
          end
        end else begin
          w_next_state = S_PLAY;
        end
      end
      S_MISS: begin
        if (r_lives <= 2'd1) begin
          w_lives      = 2'd0;
          w_next_state = S_OVER;
        end else begin
          w_lives      = r_lives - 2'd1;
          w_next_state = S_SERVE;
        end
      end
      S_CLEAR: begin
        if (bus.i_tick && (r_tick_cnt == CLEAR_LAST)) begin
          w_next_state = S_LOAD;
          w_new_game   = 1'b0;
          if (r_level >= LEVEL_TOP) begin
            w_level = LEVEL_TOP;
          end else begin
            w_level = r_level + 3'd1;
          end
        end else begin
          w_next_state = S_CLEAR;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // Counting restarts on every state change, so the entering tick is dropped
    if (w_next_state != r_state) begin
      w_tick_cnt = 4'd0;
    end else if (bus.i_tick) begin
      w_tick_cnt = r_tick_cnt + 4'd1;
    end else begin
      w_tick_cnt = r_tick_cnt;
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so they line up with it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_start_q       <= 1'b0;
      r_new_game      <= 1'b0;
      r_load_cnt      <= 1'b0;
      r_tick_cnt      <= 4'd0;
      r_lives         <= LIVES_RST;
      r_level         <= 3'd0;
      r_field_reset_n <= 1'b0;
      r_serve_req     <= 1'b0;
      r_ball_enable   <= 1'b0;
      r_game_over     <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_start_q       <= bus.i_start_btn;
      r_new_game      <= w_new_game;
      r_load_cnt      <= w_load_cnt;
      r_tick_cnt      <= w_tick_cnt;
      r_lives         <= w_lives;
      r_level         <= w_level;
      r_field_reset_n <= (w_next_state != S_LOAD);
      r_serve_req     <= (w_next_state == S_SERVE) && (r_state != S_SERVE);
      r_ball_enable   <= (w_next_state == S_PLAY);
      r_game_over     <= (w_next_state == S_OVER);
    end
  end

  assign bus.o_state         = r_state;
  assign bus.o_field_reset_n = r_field_reset_n;
  assign bus.o_serve_req     = r_serve_req;
  assign bus.o_ball_enable   = r_ball_enable;
  assign bus.o_lives         = r_lives;
  assign bus.o_level         = r_level;
  assign bus.o_game_over     = r_game_over;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: a table of per-clock vectors with expected outputs fed
// through a scoreboard queue, plus hand sequences for level saturation and async reset.
module tb_game_flow_ctrl;

  logic clk;
  logic rst;

  game_flow_if bus ();

  game_flow_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Expected output word: {state, field_reset_n, serve_req, ball_enable, lives, level, game_over}
  typedef struct packed {
    logic        start;
    logic        tick;
    logic [3:0]  row;
    logic        bz;
    logic [11:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] sb_q[$];
  int          n_checks;
  int          n_errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] mkexp(int st, bit frn, bit srv, bit ben, int lv, int lvl, bit ov);
    return {3'(st), frn, srv, ben, 2'(lv), 3'(lvl), ov};
  endfunction

  function automatic vec_t mk(bit s, bit t, int r, bit b,
                              int st, bit frn, bit srv, bit ben, int lv, int lvl, bit ov);
    vec_t v;
    v.start = s;
    v.tick  = t;
    v.row   = 4'(r);
    v.bz    = b;
    v.exp   = mkexp(st, frn, srv, ben, lv, lvl, ov);
    return v;
  endfunction

  function automatic void add(bit s, bit t, int r, bit b,
                              int st, bit frn, bit srv, bit ben, int lv, int lvl, bit ov);
    tbl.push_back(mk(s, t, r, b, st, frn, srv, ben, lv, lvl, ov));
  endfunction

  function automatic logic [11:0] outs();
    return {bus.o_state, bus.o_field_reset_n, bus.o_serve_req, bus.o_ball_enable,
            bus.o_lives, bus.o_level, bus.o_game_over};
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got st=%0d frn=%0b srv=%0b ben=%0b lives=%0d lvl=%0d over=%0b, required st=%0d frn=%0b srv=%0b ben=%0b lives=%0d lvl=%0d over=%0b",
               name, got[11:9], got[8], got[7], got[6], got[5:4], got[3:1], got[0],
               exp[11:9], exp[8], exp[7], exp[6], exp[5:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic drive(input logic s, input logic t, input logic [3:0] r, input logic b);
    bus.i_start_btn = s;
    bus.i_tick      = t;
    bus.i_ball_row  = r;
    bus.i_bricks    = b ? 72'd0 : 72'd5;
  endtask

  task automatic step(input vec_t v, input string name);
    logic [11:0] e;
    drive(v.start, v.tick, v.row, v.bz);
    sb_q.push_back(v.exp);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got empty scoreboard, required one pending entry", name);
    end else begin
      e = sb_q.pop_front();
      check(name, outs(), e);
    end
  endtask

  // One full level from the second SERVE clock: serve, play, clear, reload, back to SERVE
  task automatic clear_level(input int cur, input int nxt, input int k);
    string n;
    n = $sformatf("clear%0d", k);
    step(mk(0, 0, 0, 0, 2, 1, 0, 0, 3, cur, 0), n);
    for (int i = 0; i < 3; i++) step(mk(0, 1, 0, 0, 2, 1, 0, 0, 3, cur, 0), n);
    step(mk(0, 1, 0, 0, 3, 1, 0, 1, 3, cur, 0), n);
    step(mk(0, 1, 0, 1, 5, 1, 0, 0, 3, cur, 0), n);
    step(mk(0, 0, 0, 1, 5, 1, 0, 0, 3, cur, 0), n);
    for (int i = 0; i < 5; i++) step(mk(0, 1, 0, 1, 5, 1, 0, 0, 3, cur, 0), n);
    step(mk(0, 1, 0, 1, 1, 0, 0, 0, 3, nxt, 0), n);
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 3, nxt, 0), n);
    step(mk(0, 0, 0, 0, 2, 1, 1, 0, 3, nxt, 0), n);
  endtask

  initial begin
    int lvl;
    int nxt;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b0);

    // Start, LOAD for two clocks, serve pulse, four ticks into PLAY
    add(0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0);
    add(1, 0, 0, 0, 2, 1, 1, 0, 3, 0, 0);
    add(0, 0, 0, 0, 2, 1, 0, 0, 3, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 2, 1, 0, 0, 3, 0, 0);
    add(0, 1, 0, 0, 3, 1, 0, 1, 3, 0, 0);
    // Start edge and loss row without a tick: PLAY holds
    add(1, 0, 11, 0, 3, 1, 0, 1, 3, 0, 0);
    add(0, 1, 11, 0, 4, 1, 0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 2, 1, 1, 0, 2, 0, 0);
    add(0, 0, 0, 0, 2, 1, 0, 0, 2, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 2, 1, 0, 0, 2, 0, 0);
    add(0, 1, 0, 0, 3, 1, 0, 1, 2, 0, 0);
    add(0, 1, 11, 0, 4, 1, 0, 0, 2, 0, 0);
    add(0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 0);
    // Start goes high in SERVE and stays high into OVER
    add(1, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 2, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 3, 1, 0, 1, 1, 0, 0);
    add(1, 1, 11, 0, 4, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1);
    add(1, 1, 11, 0, 6, 1, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1);
    // Fresh edge restarts with full lives
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 2, 1, 1, 0, 3, 0, 0);
    add(0, 0, 0, 0, 2, 1, 0, 0, 3, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 2, 1, 0, 0, 3, 0, 0);
    add(0, 1, 0, 0, 3, 1, 0, 1, 3, 0, 0);
    // Empty field and loss row on the same tick: CLEAR wins
    add(0, 1, 11, 1, 5, 1, 0, 0, 3, 0, 0);
    add(0, 0, 0, 1, 5, 1, 0, 0, 3, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 5, 1, 0, 0, 3, 0, 0);
    add(0, 1, 0, 1, 1, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 2, 1, 1, 0, 3, 1, 0);

    #2;
    check("reset_async", outs(), mkexp(0, 0, 0, 0, 3, 0, 0));
    @(negedge clk);
    check("reset_held", outs(), mkexp(0, 0, 0, 0, 3, 0, 0));
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    lvl = 1;
    for (int k = 0; k < 8; k++) begin
      nxt = (lvl < 7) ? lvl + 1 : 7;
      clear_level(lvl, nxt, k);
      lvl = nxt;
    end

    // Into PLAY at level 7, then reset in the middle of a tick cycle
    step(mk(0, 0, 0, 0, 2, 1, 0, 0, 3, 7, 0), "pre_rst");
    for (int i = 0; i < 3; i++) step(mk(0, 1, 0, 0, 2, 1, 0, 0, 3, 7, 0), "pre_rst");
    step(mk(0, 1, 0, 0, 3, 1, 0, 1, 3, 7, 0), "pre_rst");
    drive(1'b0, 1'b1, 4'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_play", outs(), mkexp(0, 0, 0, 0, 3, 0, 0));
    @(negedge clk);
    check("rst_over_edge", outs(), mkexp(0, 0, 0, 0, 3, 0, 0));
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("rst_release", outs(), mkexp(0, 1, 0, 0, 3, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
